// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the byte-lane helper for the SRAM responder.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01
    } hresp_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'b000,
        HSIZE_HALF = 3'b001,
        HSIZE_WORD = 3'b010
    } hsize_e;

    typedef enum logic [2:0] {
        RS_IDLE = 3'd0,
        RS_WAIT = 3'd1,
        RS_DONE = 3'd2,
        RS_ERR1 = 3'd3,
        RS_ERR2 = 3'd4
    } resp_state_e;

    function automatic logic [3:0] be_from_size(input logic [2:0] size, input logic [1:0] addr);
        logic [3:0] be;
        case (size)
            3'b000:  be = 4'b0001 << addr;
            3'b001:  be = addr[1] ? 4'b1100 : 4'b0011;
            3'b010:  be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/ahb_sram_responder_array.sv
// Word-wide flop array with per-byte write enables and an asynchronous read port.
module ahb_sram_array #(
    parameter int unsigned DEPTH = 32768
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [3:0]               i_be,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  logic [31:0]              i_wdata,
    output logic [31:0]              o_rdata
);

    logic [31:0] r_mem [DEPTH];

    // No reset: contents are undefined at power-up, like the SRAM being modelled.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (i_we && i_be[b]) begin
                r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/ahb_sram_responder.sv
// AHB-Lite slave in front of a word-addressable SRAM window, with programmable
// wait states and a two-cycle ERROR response for illegal accesses.
//
//   state | meaning
//   IDLE  | ready, no data phase pending
//   WAIT  | data phase stalled, wait-state counter running
//   DONE  | OKAY completion; write commits / read data driven
//   ERR1  | first ERROR cycle, hready low
//   ERR2  | second ERROR cycle, hready high
module ahb_sram_responder
    import ahb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0100_0000,
    parameter int unsigned DEPTH        = 32768,
    parameter int unsigned WAIT_STATES  = 1,
    parameter bit          USE_HREADYIN = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ahb_if_haddr,
    input  logic        ahb_if_hwrite,
    input  logic [31:0] ahb_if_hwdata,
    input  logic [1:0]  ahb_if_htrans,
    input  logic [2:0]  ahb_if_hsize,
    input  logic        ahb_if_hsel,
    input  logic [2:0]  ahb_if_hburst,
    input  logic        ahb_if_hreadyin,
    output logic        ahb_if_hready,
    output logic [31:0] ahb_if_hrdata,
    output logic [1:0]  ahb_if_hresp
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + (33'(DEPTH) << 2);
    localparam logic [3:0]  WS       = 4'(WAIT_STATES);

    localparam logic [2:0] S_IDLE = 3'(RS_IDLE);
    localparam logic [2:0] S_WAIT = 3'(RS_WAIT);
    localparam logic [2:0] S_DONE = 3'(RS_DONE);
    localparam logic [2:0] S_ERR1 = 3'(RS_ERR1);
    localparam logic [2:0] S_ERR2 = 3'(RS_ERR2);

    logic [2:0]    r_state;
    logic [2:0]    w_next_state;
    logic [3:0]    r_cnt;
    logic [3:0]    w_next_cnt;
    logic [AW-1:0] r_index;
    logic          r_write;
    logic [3:0]    r_be;

    logic          w_hready;
    logic          w_accept;
    logic          w_in_range;
    logic          w_size_ok;
    logic          w_aligned;
    logic          w_legal;
    logic          w_we;
    logic [31:0]   w_offset;
    logic [31:0]   w_rdata;
    logic          w_unused;

    assign w_offset   = ahb_if_haddr - BASE_ADDR;
    assign w_in_range = ({1'b0, ahb_if_haddr} >= {1'b0, BASE_ADDR}) &&
                        ({1'b0, ahb_if_haddr} < END_ADDR);
    assign w_size_ok  = (ahb_if_hsize <= 3'b010);

    always_comb begin
        w_aligned = 1'b1;
        case (ahb_if_hsize)
            3'b001:  w_aligned = ~ahb_if_haddr[0];
            3'b010:  w_aligned = (ahb_if_haddr[1:0] == 2'b00);
            default: w_aligned = 1'b1;
        endcase
    end

    assign w_legal  = w_in_range && w_size_ok && w_aligned;
    assign w_hready = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR2);
    assign w_accept = ahb_if_hsel && ahb_if_htrans[1] && w_hready &&
                      (USE_HREADYIN ? ahb_if_hreadyin : 1'b1);

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            S_WAIT: begin
                w_next_cnt = r_cnt - 4'd1;
                if (r_cnt <= 4'd1) begin
                    w_next_state = S_DONE;
                end
            end
            S_ERR1: w_next_state = S_ERR2;
            S_IDLE, S_DONE, S_ERR2: begin
                if (w_accept) begin
                    if (!w_legal) begin
                        w_next_state = S_ERR1;
                    end else if (WS != 4'd0) begin
                        w_next_state = S_WAIT;
                        w_next_cnt   = WS;
                    end else begin
                        w_next_state = S_DONE;
                    end
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_index <= '0;
            r_write <= 1'b0;
            r_be    <= 4'b0000;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            if (w_accept) begin
                r_index <= w_offset[AW+1:2];
                r_write <= ahb_if_hwrite;
                r_be    <= be_from_size(ahb_if_hsize, ahb_if_haddr[1:0]);
            end
        end
    end

    // Gated by rst_n so a reset landing on the DONE edge still drops the write.
    assign w_we = rst_n && (r_state == S_DONE) && r_write;

    ahb_sram_array #(.DEPTH(DEPTH)) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_be    (r_be),
        .i_addr  (r_index),
        .i_wdata (ahb_if_hwdata),
        .o_rdata (w_rdata)
    );

    assign ahb_if_hready = w_hready;
    assign ahb_if_hresp  = ((r_state == S_ERR1) || (r_state == S_ERR2)) ? 2'(HRESP_ERROR)
                                                                         : 2'(HRESP_OKAY);
    assign ahb_if_hrdata = ((r_state == S_DONE) && !r_write) ? w_rdata : 32'h0;

    assign w_unused = ^{ahb_if_htrans[0], ahb_if_hburst, ahb_if_hreadyin,
                        w_offset[31:AW+2], w_offset[1:0]};

endmodule

// File: tb/tb_ahb_sram_responder.sv
// Randomized and directed bench for ahb_sram_responder: instance 0 has one wait
// state, instance 1 has none; both are checked against a transaction-level model.
module tb_ahb_sram_responder;

    localparam logic [31:0] BASE  = 32'h0100_0000;
    localparam int          DEPTH = 32768;

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] haddr [2];
    logic [31:0] hwdata [2];
    logic [31:0] hrdata [2];
    logic        hwrite [2];
    logic        hsel [2];
    logic        hreadyin [2];
    logic        hready [2];
    logic [1:0]  htrans [2];
    logic [1:0]  hresp [2];
    logic [2:0]  hsize [2];
    logic [2:0]  hburst [2];

    int          n_checks = 0;
    int          n_fail = 0;
    txn_t        q[$];
    logic [31:0] mdl [int];
    logic [31:0] last_rdata;

    always #5 clk = ~clk;

    ahb_sram_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_STATES(1), .USE_HREADYIN(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .ahb_if_haddr(haddr[0]), .ahb_if_hwrite(hwrite[0]), .ahb_if_hwdata(hwdata[0]),
        .ahb_if_htrans(htrans[0]), .ahb_if_hsize(hsize[0]), .ahb_if_hsel(hsel[0]),
        .ahb_if_hburst(hburst[0]), .ahb_if_hreadyin(hreadyin[0]),
        .ahb_if_hready(hready[0]), .ahb_if_hrdata(hrdata[0]), .ahb_if_hresp(hresp[0])
    );

    ahb_sram_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_STATES(0), .USE_HREADYIN(1'b0)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .ahb_if_haddr(haddr[1]), .ahb_if_hwrite(hwrite[1]), .ahb_if_hwdata(hwdata[1]),
        .ahb_if_htrans(htrans[1]), .ahb_if_hsize(hsize[1]), .ahb_if_hsel(hsel[1]),
        .ahb_if_hburst(hburst[1]), .ahb_if_hreadyin(hreadyin[1]),
        .ahb_if_hready(hready[1]), .ahb_if_hrdata(hrdata[1]), .ahb_if_hresp(hresp[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int ws_of(input int d);
        return (d == 0) ? 1 : 0;
    endfunction

    function automatic bit legal(input txn_t t);
        longint a;
        a = longint'(t.addr);
        if (a < longint'(BASE) || a >= longint'(BASE) + 4 * DEPTH) return 1'b0;
        if (t.size > 3'd2) return 1'b0;
        return (t.addr % (32'd1 << t.size)) == 32'd0;
    endfunction

    function automatic int key_of(input int d, input logic [31:0] addr);
        return d * DEPTH + int'((addr - BASE) >> 2);
    endfunction

    task automatic mdl_write(input int d, input txn_t t);
        int          key;
        int          nb;
        int          lane0;
        logic [31:0] w;
        key   = key_of(d, t.addr);
        nb    = 1 << t.size;
        lane0 = int'(t.addr[1:0]);
        if (nb == 4) begin
            mdl[key] = t.wdata;
        end else if (mdl.exists(key)) begin
            w = mdl[key];
            for (int k = 0; k < nb; k++) w[8*(lane0+k) +: 8] = t.wdata[8*(lane0+k) +: 8];
            mdl[key] = w;
        end
    endtask

    function automatic txn_t mk(input logic sel, input logic [1:0] trans, input logic wr,
                                input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata);
        txn_t t;
        t.sel = sel; t.trans = trans; t.wr = wr; t.size = size; t.addr = addr; t.wdata = wdata;
        return t;
    endfunction

    task automatic drive_addr(input int d, input int i);
        if (i < q.size()) begin
            hsel[d]   = q[i].sel;
            htrans[d] = q[i].trans;
            hwrite[d] = q[i].wr;
            hsize[d]  = q[i].size;
            haddr[d]  = q[i].addr;
            hburst[d] = 3'($urandom_range(0, 7));
        end else begin
            hsel[d]   = 1'b0;
            htrans[d] = 2'b00;
        end
    endtask

    // Plays q on instance d as a pipelined AHB master and checks every cycle.
    task automatic run_q(input int d);
        int   idx = 0;
        bit   busy = 1'b0;
        bit   acc;
        bit   lg;
        int   low = 0;
        int   exp_low;
        int   budget = 0;
        int   key;
        txn_t cur;
        drive_addr(d, 0);
        while ((idx < q.size() || busy) && budget < 5000) begin
            @(negedge clk);
            budget++;
            if (busy) begin
                lg      = legal(cur);
                exp_low = lg ? ws_of(d) : 1;
                if (!hready[d]) begin
                    low++;
                    chk("wait_resp", 32'(hresp[d]), lg ? 32'd0 : 32'd1);
                    chk("wait_rdata", hrdata[d], 32'd0);
                    if (low > exp_low) begin
                        chk("wait_len", 32'(low), 32'(exp_low));
                        busy = 1'b0;
                    end
                end else begin
                    chk("wait_len", 32'(low), 32'(exp_low));
                    chk("resp", 32'(hresp[d]), lg ? 32'd0 : 32'd1);
                    if (lg && !cur.wr) begin
                        last_rdata = hrdata[d];
                        key = key_of(d, cur.addr);
                        if (mdl.exists(key)) chk("rdata", hrdata[d], mdl[key]);
                    end else begin
                        chk("rdata_zero", hrdata[d], 32'd0);
                    end
                    if (lg && cur.wr) mdl_write(d, cur);
                    busy = 1'b0;
                end
            end else begin
                chk("idle_ready", 32'(hready[d]), 32'd1);
                chk("idle_resp", 32'(hresp[d]), 32'd0);
                chk("idle_rdata", hrdata[d], 32'd0);
            end
            acc = hready[d] && (idx < q.size());
            @(posedge clk);
            #1;
            if (acc) begin
                if (q[idx].sel && q[idx].trans[1]) begin
                    cur       = q[idx];
                    busy      = 1'b1;
                    low       = 0;
                    hwdata[d] = cur.wdata;
                end
                idx++;
                drive_addr(d, idx);
            end
        end
        if (budget >= 5000) chk("cycle_budget", 32'd0, 32'd1);
        q.delete();
    endtask

    localparam int POOL_N = 8;
    int pool [POOL_N] = '{0, 1, 2, 3, 5, 100, DEPTH - 2, DEPTH - 1};

    function automatic txn_t rand_txn();
        int          kind;
        logic [2:0]  sz;
        logic [31:0] a;
        kind = $urandom_range(0, 99);
        sz   = 3'($urandom_range(0, 2));
        a    = BASE + 32'(pool[$urandom_range(0, POOL_N - 1)]) * 4;
        if (kind < 70) begin
            a = a + (32'($urandom_range(0, 3)) & ~((32'd1 << sz) - 32'd1));
            return mk(1'b1, $urandom_range(0, 1) ? 2'b10 : 2'b11, 1'($urandom_range(0, 1)), sz, a, $urandom);
        end else if (kind < 75) begin
            return mk(1'b1, 2'b10, 1'b1, 3'd2, BASE + 4 * DEPTH + 32'($urandom_range(0, 15)) * 4, $urandom);
        end else if (kind < 80) begin
            return mk(1'b1, 2'b10, 1'b0, 3'd2, BASE - 32'd4, $urandom);
        end else if (kind < 85) begin
            return mk(1'b1, 2'b10, 1'($urandom_range(0, 1)), 3'($urandom_range(3, 7)), a, $urandom);
        end else if (kind < 90) begin
            return mk(1'b1, 2'b11, 1'b1, $urandom_range(0, 1) ? 3'd1 : 3'd2, a + 32'd1, $urandom);
        end else if (kind < 95) begin
            return mk(1'b1, 2'b01, 1'b1, 3'd2, a, $urandom);
        end else begin
            return mk(1'b0, 2'b10, 1'b1, 3'd2, a, $urandom);
        end
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            haddr[d] = 32'd0; hwdata[d] = 32'd0; hwrite[d] = 1'b0; hsel[d] = 1'b0;
            hreadyin[d] = 1'b0; htrans[d] = 2'b00; hsize[d] = 3'd0; hburst[d] = 3'd0;
        end
        last_rdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset_hready", 32'(hready[d]), 32'd1);
            chk("reset_hresp", 32'(hresp[d]), 32'd0);
            chk("reset_hrdata", hrdata[d], 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        q.push_back(mk(1'b1, 2'b10, 1'b1, 3'd2, 32'h0100_0010, 32'hDEAD_BEEF));
        q.push_back(mk(1'b1, 2'b10, 1'b0, 3'd2, 32'h0100_0010, 32'h0));
        run_q(0);
        chk("readback_word", last_rdata, 32'hDEAD_BEEF);

        q.push_back(mk(1'b1, 2'b10, 1'b1, 3'd2, 32'h0100_0010, 32'h1122_3344));
        q.push_back(mk(1'b1, 2'b10, 1'b1, 3'd0, 32'h0100_0013, 32'hAA00_0000));
        q.push_back(mk(1'b1, 2'b10, 1'b0, 3'd2, 32'h0100_0010, 32'h0));
        run_q(0);
        chk("byte_merge", last_rdata, 32'hAA22_3344);

        q.push_back(mk(1'b1, 2'b10, 1'b1, 3'd2, 32'h0100_0000, 32'h5555_AAAA));
        q.push_back(mk(1'b1, 2'b10, 1'b1, 3'd2, 32'h0102_0000, 32'hFFFF_FFFF));
        q.push_back(mk(1'b1, 2'b10, 1'b0, 3'd2, 32'h0100_0000, 32'h0));
        run_q(0);
        chk("oob_no_write", last_rdata, 32'h5555_AAAA);

        q.push_back(mk(1'b1, 2'b10, 1'b0, 3'd1, 32'h0100_0001, 32'h0));
        q.push_back(mk(1'b1, 2'b10, 1'b0, 3'd3, 32'h0100_0010, 32'h0));
        q.push_back(mk(1'b1, 2'b10, 1'b0, 3'd2, 32'h0100_0010, 32'h0));
        run_q(0);
        chk("after_err_read", last_rdata, 32'hAA22_3344);

        q.push_back(mk(1'b1, 2'b10, 1'b1, 3'd2, 32'h0100_0040, 32'hCAFE_F00D));
        q.push_back(mk(1'b1, 2'b10, 1'b0, 3'd2, 32'h0100_0040, 32'h0));
        run_q(1);
        chk("pipelined_raw", last_rdata, 32'hCAFE_F00D);

        // Reset during the wait state of a write must drop the write.
        q.push_back(mk(1'b1, 2'b10, 1'b1, 3'd2, 32'h0100_0020, 32'h0123_4567));
        run_q(0);
        @(negedge clk);
        hsel[0] = 1'b1; htrans[0] = 2'b10; hwrite[0] = 1'b1; hsize[0] = 3'd2; haddr[0] = 32'h0100_0020;
        @(posedge clk);
        #1;
        hsel[0] = 1'b0; htrans[0] = 2'b00; hwdata[0] = 32'h89AB_CDEF;
        @(negedge clk);
        chk("rst_wait_hready", 32'(hready[0]), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_hready", 32'(hready[0]), 32'd1);
        chk("rst_mid_hresp", 32'(hresp[0]), 32'd0);
        chk("rst_mid_hrdata", hrdata[0], 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        q.push_back(mk(1'b1, 2'b10, 1'b0, 3'd2, 32'h0100_0020, 32'h0));
        run_q(0);
        chk("rst_no_write", last_rdata, 32'h0123_4567);

        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < POOL_N; p++) begin
                q.push_back(mk(1'b1, 2'b10, 1'b1, 3'd2, BASE + 32'(pool[p]) * 4, $urandom));
            end
            for (int n = 0; n < 200; n++) q.push_back(rand_txn());
            run_q(d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
